// File: rtl/r2r_dac_wavegen_if.sv
// r2r_dac_wavegen_if: control and code bus between the tile decode and the R2R DAC front end.
//   master drives ena, mode, div, step, static_code, play_len, wr_en/wr_addr/wr_data
//   and receives dac_code, sample_tick, wrap; slave is the generator side.
interface r2r_dac_wavegen_if #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16,
   parameter int DEPTH     = 16
);
   localparam int AW = $clog2(DEPTH);
   logic                 ena;
   logic [1:0]           mode;
   logic [DIV_WIDTH-1:0] div;
   logic [WIDTH-1:0]     step;
   logic [WIDTH-1:0]     static_code;
   logic [AW-1:0]        play_len;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic [WIDTH-1:0]     dac_code;
   logic                 sample_tick;
   logic                 wrap;
   modport master (
      output ena, mode, div, step, static_code, play_len, wr_en, wr_addr, wr_data,
      input  dac_code, sample_tick, wrap
   );
   modport slave (
      input  ena, mode, div, step, static_code, play_len, wr_en, wr_addr, wr_data,
      output dac_code, sample_tick, wrap
   );
endinterface

// File: rtl/r2r_dac_wavegen.sv
// r2r_dac_wavegen: HOLD/SAW/TRI/PLAY code generator feeding the R2R DAC ladder at a divided sample rate.
//   clk, rst_n (async, active-low) are plain ports; everything else travels on bus (slave modport):
//   controls in (ena, mode, div, step, static_code, play_len, sample write port),
//   registered dac_code, sample_tick and wrap out.
module r2r_dac_wavegen #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16,
   parameter int DEPTH     = 16
) (
   input logic             clk,
   input logic             rst_n,
   r2r_dac_wavegen_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [WIDTH:0] TOP = {1'b0, {WIDTH{1'b1}}};
   typedef enum logic {UP, DOWN} dir_t;
   logic [DIV_WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0]     acc, acc_n, code, code_n;
   logic [AW-1:0]        ptr, ptr_n;
   logic [1:0]           mode_q;
   dir_t                 dir, dir_n;
   logic                 tick_q, wrap_q, wrap_n;
   logic [WIDTH-1:0]     mem [DEPTH];
   logic [WIDTH:0]       sum;
   logic                 mode_chg, tick, low;
   assign mode_chg = bus.mode != mode_q;
   // a mode change swallows the tick so the new waveform starts from a clean state
   assign tick = bus.ena && !mode_chg && cnt == bus.div;
   // one bit wider so SAW sees the carry and TRI can detect overshoot of full scale
   assign sum = {1'b0, acc} + {1'b0, bus.step};
   assign low = acc <= bus.step;
   assign bus.dac_code = code;
   assign bus.sample_tick = tick_q;
   assign bus.wrap = wrap_q;
   always_comb begin
      cnt_n  = (!bus.ena || mode_chg || tick) ? '0 : cnt + 1'b1;
      acc_n  = acc;
      dir_n  = dir;
      ptr_n  = ptr;
      code_n = code;
      wrap_n = 1'b0;
      if (mode_chg) begin
         acc_n = '0;
         dir_n = UP;
         ptr_n = '0;
      end else if (tick) begin
         code_n = acc;
         case (mode_q)
            2'd0: code_n = bus.static_code;
            2'd1: begin
               acc_n  = sum[WIDTH-1:0];
               wrap_n = sum[WIDTH];
            end
            2'd2: if (dir == UP) begin
               acc_n = sum >= TOP ? TOP[WIDTH-1:0] : sum[WIDTH-1:0];
               dir_n = sum >= TOP ? DOWN : UP;
            end else begin
               acc_n  = low ? '0 : acc - bus.step;
               dir_n  = low ? UP : DOWN;
               wrap_n = low;
            end
            default: begin
               // mem is read before this edge's write lands, giving read-before-write
               code_n = mem[ptr];
               ptr_n  = ptr == bus.play_len ? '0 : ptr + 1'b1;
               wrap_n = ptr == bus.play_len;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         dir    <= UP;
         ptr    <= '0;
         mode_q <= '0;
         code   <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         cnt    <= cnt_n;
         acc    <= acc_n;
         dir    <= dir_n;
         ptr    <= ptr_n;
         mode_q <= bus.mode;
         code   <= code_n;
         tick_q <= tick;
         wrap_q <= wrap_n;
         if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      end
   end
endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// tb_r2r_dac_wavegen: directed scenarios for r2r_dac_wavegen with hand-computed code sequences.
module tb_r2r_dac_wavegen;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   r2r_dac_wavegen_if #(.WIDTH(8), .DIV_WIDTH(16), .DEPTH(16)) bus ();
   r2r_dac_wavegen #(.WIDTH(8), .DIV_WIDTH(16), .DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      repeat (2) cyc;
      n_cmp++; if (bus.dac_code !== 8'h00) begin n_bad++; $display("FAIL reset_code: got %h want 00", bus.dac_code); end
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", bus.sample_tick); end
      n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", bus.wrap); end
      #2 rst_n = 1;
   endtask
   task automatic test_hold;
      bus.ena = 1; bus.div = 0; bus.static_code = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         cyc;
         n_cmp++; if (bus.dac_code !== 8'hA5) begin n_bad++; $display("FAIL hold_code[%0d]: got %h want a5", i, bus.dac_code); end
         n_cmp++; if (bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL hold_tick[%0d]: got %b want 1", i, bus.sample_tick); end
         n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL hold_wrap[%0d]: got %b want 0", i, bus.wrap); end
      end
   endtask
   task automatic test_saw;
      logic [7:0] exp [7] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80};
      bus.mode = 1; bus.step = 8'h40; bus.div = 3;
      cyc;
      n_cmp++; if (bus.dac_code !== 8'hA5 || bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL saw_modechg: got %h/%b want a5/0", bus.dac_code, bus.sample_tick); end
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 3; j++) begin
            cyc;
            n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL saw_idle[%0d.%0d]: got %b want 0", i, j, bus.sample_tick); end
         end
         cyc;
         n_cmp++; if (bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL saw_tick[%0d]: got %b want 1", i, bus.sample_tick); end
         n_cmp++; if (bus.dac_code !== exp[i]) begin n_bad++; $display("FAIL saw_code[%0d]: got %h want %h", i, bus.dac_code, exp[i]); end
         n_cmp++; if (bus.wrap !== (exp[i] == 8'hC0)) begin n_bad++; $display("FAIL saw_wrap[%0d]: got %b want %b", i, bus.wrap, exp[i] == 8'hC0); end
      end
   endtask
   task automatic test_ena_and_mode;
      bus.ena = 0;
      for (int i = 0; i < 10; i++) begin
         cyc;
         n_cmp++; if (bus.dac_code !== 8'h80 || bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL ena_hold[%0d]: got %h/%b want 80/0", i, bus.dac_code, bus.sample_tick); end
      end
      bus.ena = 1;
      repeat (3) cyc;
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL ena_resume_idle: got %b want 0", bus.sample_tick); end
      cyc;
      n_cmp++; if (bus.dac_code !== 8'hC0 || bus.sample_tick !== 1'b1 || bus.wrap !== 1'b1) begin n_bad++; $display("FAIL ena_resume: got %h/%b/%b want c0/1/1", bus.dac_code, bus.sample_tick, bus.wrap); end
      bus.mode = 2;
      cyc;
      n_cmp++; if (bus.dac_code !== 8'hC0 || bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL tri_switch_hold: got %h/%b want c0/0", bus.dac_code, bus.sample_tick); end
      repeat (3) cyc;
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL tri_switch_idle: got %b want 0", bus.sample_tick); end
      cyc;
      n_cmp++; if (bus.dac_code !== 8'h00 || bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL tri_switch_first: got %h/%b want 00/1", bus.dac_code, bus.sample_tick); end
   endtask
   task automatic test_tri;
      logic [7:0] exp [8] = '{8'h00, 8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};
      bus.mode = 0;
      cyc;
      bus.mode = 2; bus.step = 8'h60; bus.div = 0;
      cyc;
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL tri_modechg: got %b want 0", bus.sample_tick); end
      for (int i = 0; i < 8; i++) begin
         cyc;
         n_cmp++; if (bus.dac_code !== exp[i] || bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL tri_code[%0d]: got %h/%b want %h/1", i, bus.dac_code, bus.sample_tick, exp[i]); end
         n_cmp++; if (bus.wrap !== (i == 5)) begin n_bad++; $display("FAIL tri_wrap[%0d]: got %b want %b", i, bus.wrap, i == 5); end
      end
   endtask
   task automatic test_play;
      logic [7:0] wd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] ex1 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      logic [7:0] ex2 [4] = '{8'h33, 8'h44, 8'h11, 8'h99};
      for (int i = 0; i < 4; i++) begin
         bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = wd[i];
         cyc;
      end
      bus.wr_en = 0; bus.play_len = 3; bus.div = 1; bus.mode = 3;
      cyc;
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL play_modechg: got %b want 0", bus.sample_tick); end
      for (int i = 0; i < 5; i++) begin
         cyc;
         n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL play_idle[%0d]: got %b want 0", i, bus.sample_tick); end
         cyc;
         n_cmp++; if (bus.dac_code !== ex1[i] || bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL play_code[%0d]: got %h/%b want %h/1", i, bus.dac_code, bus.sample_tick, ex1[i]); end
         n_cmp++; if (bus.wrap !== (i == 3)) begin n_bad++; $display("FAIL play_wrap[%0d]: got %b want %b", i, bus.wrap, i == 3); end
      end
      cyc;
      bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 8'h99;
      cyc;
      bus.wr_en = 0;
      n_cmp++; if (bus.dac_code !== 8'h22 || bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL play_rbw: got %h/%b want 22/1", bus.dac_code, bus.sample_tick); end
      for (int i = 0; i < 4; i++) begin
         cyc;
         cyc;
         n_cmp++; if (bus.dac_code !== ex2[i] || bus.wrap !== (i == 1)) begin n_bad++; $display("FAIL play_pass2[%0d]: got %h/%b want %h/%b", i, bus.dac_code, bus.wrap, ex2[i], i == 1); end
      end
   endtask
   task automatic test_async_reset;
      bus.div = 0;
      cyc;
      n_cmp++; if (bus.dac_code !== 8'h33 || bus.sample_tick !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got %h/%b want 33/1", bus.dac_code, bus.sample_tick); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if (bus.dac_code !== 8'h00 || bus.sample_tick !== 1'b0 || bus.wrap !== 1'b0) begin n_bad++; $display("FAIL areset_now: got %h/%b/%b want 00/0/0", bus.dac_code, bus.sample_tick, bus.wrap); end
      bus.mode = 3; bus.play_len = 15; bus.ena = 1;
      #3 rst_n = 1;
      cyc;
      n_cmp++; if (bus.sample_tick !== 1'b0) begin n_bad++; $display("FAIL areset_modechg: got %b want 0", bus.sample_tick); end
      for (int i = 0; i < 16; i++) begin
         cyc;
         n_cmp++; if (bus.dac_code !== 8'h00 || bus.sample_tick !== 1'b1 || bus.wrap !== (i == 15)) begin n_bad++; $display("FAIL areset_mem[%0d]: got %h/%b/%b want 00/1/%b", i, bus.dac_code, bus.sample_tick, bus.wrap, i == 15); end
      end
   endtask
   initial begin
      rst_n = 0;
      bus.ena = 0; bus.mode = 0; bus.div = 0; bus.step = 0; bus.static_code = 0;
      bus.play_len = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
      test_reset;
      test_hold;
      test_saw;
      test_ena_and_mode;
      test_tri;
      test_play;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
